// File: rtl/shift_issue.sv
// shift_issue: issue register for a 5-stage rotate chain (16/8/4/2/1).
// It registers the operand, direction and per-stage enables with a
// valid/ready handshake on both sides. It also counts completed output
// handshakes in a saturating counter.
// Optional build macro: SHIFT_ISSUE_SKID_EN compiles in a one-entry skid
// buffer, which makes in_ready a registered signal.
module shift_issue #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_dir,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              dir,
    output logic [AMT_W-1:0]  ena,
    output logic [15:0]       issue_cnt
);

    logic              accept;
    logic              drain;
    logic              out_free;
    logic              out_load;
    logic              out_valid_nxt;
    logic [DATA_W-1:0] load_data;
    logic [AMT_W-1:0]  load_amt;
    logic              load_dir;

    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign out_free = !out_valid || out_ready;

`ifdef SHIFT_ISSUE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [AMT_W-1:0]  skid_amt;
    logic              skid_dir;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid_nxt;
    logic              rdy_q;

    // The registered ready is gated by rst so that it reads low during reset.
    // Its reset value of 1 still allows an accept on the first edge after release.
    assign in_ready = rdy_q && !rst;

    // The skid entry drains into the output first, which keeps acceptance order.
    // A new request fills the skid entry only when the output is stalled.
    always_comb begin
        out_load   = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        load_data  = in_data;
        load_amt   = in_amt;
        load_dir   = in_dir;
        if (out_free) begin
            if (skid_valid) begin
                out_load   = 1'b1;
                skid_clear = 1'b1;
                load_data  = skid_data;
                load_amt   = skid_amt;
                load_dir   = skid_dir;
            end else if (accept) begin
                out_load = 1'b1;
            end
        end else if (accept) begin
            skid_load = 1'b1;
        end
        skid_valid_nxt = skid_load ? 1'b1 : (skid_clear ? 1'b0 : skid_valid);
    end

    // Skid entry storage and registered ready (high while the entry is empty)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_amt   <= '0;
            skid_dir   <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            skid_valid <= skid_valid_nxt;
            rdy_q      <= !skid_valid_nxt;
            if (skid_load) begin
                skid_data <= in_data;
                skid_amt  <= in_amt;
                skid_dir  <= in_dir;
            end
        end
    end
`else
    // Without a skid entry, a request is accepted only when the output
    // register is empty or is draining in the same cycle.
    assign in_ready = !rst && out_free;

    // The output loads directly from the input on every accept
    always_comb begin
        out_load  = accept;
        load_data = in_data;
        load_amt  = in_amt;
        load_dir  = in_dir;
    end
`endif

    // The output valid flag is set by a load and cleared by a drain that has no reload
    always_comb begin
        out_valid_nxt = out_valid;
        if (out_load) begin
            out_valid_nxt = 1'b1;
        end else if (drain) begin
            out_valid_nxt = 1'b0;
        end
    end

    // Output register: operand, direction and stage enables (ena = amount)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            dir       <= 1'b0;
            ena       <= '0;
        end else begin
            out_valid <= out_valid_nxt;
            if (out_load) begin
                data_out <= load_data;
                dir      <= load_dir;
                ena      <= load_amt;
            end
        end
    end

    // Saturating count of completed output handshakes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
        end else if (drain && (issue_cnt != '1)) begin
            issue_cnt <= issue_cnt + 16'd1;
        end
    end

endmodule

// File: doc/shift_issue.md
SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 Parameter: DATA_W, default 32, operand width; SHALL be 32 in this design.
REQ-002 Parameter: AMT_W, default 5, shift-amount width; SHALL equal log2(DATA_W).
REQ-003 Port: clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  request accepted when in_valid && in_ready at clk edge.
REQ-007 Port: in_data  input  32  operand to rotate.
REQ-008 Port: in_amt  input  5  rotate amount, 0..31.
REQ-009 Port: in_dir  input  1  0 = rotate left, 1 = rotate right.
REQ-010 Port: out_valid  output  1  issued operand and enables valid.
REQ-011 Port: out_ready  input  1  downstream stage chain accepts when out_valid && out_ready.
REQ-012 Port: data_out  output  32  registered operand feeding the 16-bit rotate stage.
REQ-013 Port: dir  output  1  registered direction for all stages.
REQ-014 Port: ena  output  5  registered stage enables; bit4 = 16-stage, bit3 = 8, bit2 = 4, bit1 = 2, bit0 = 1.
REQ-015 Port: issue_cnt  output  16  count of completed output handshakes.

Function
REQ-016 ena SHALL equal in_amt of the accepted request, unmodified, registered with data_out and dir.
REQ-017 Issue latency SHALL be exactly 1 cycle: a request accepted at edge N SHALL appear on data_out/dir/ena with out_valid high after edge N.
REQ-018 data_out, dir, ena SHALL hold stable while out_valid && !out_ready.
REQ-019 Output register SHALL load on accept when empty or when draining in the same cycle (out_ready high).
REQ-020 Simultaneous output drain and input accept SHALL sustain one request per cycle with no bubble.
REQ-021 in_amt = 0 SHALL issue ena = 5'b00000 (pass-through); in_amt = 31 SHALL issue ena = 5'b11111.
REQ-022 issue_cnt SHALL increment by 1 on every out_valid && out_ready edge and saturate at 16'hFFFF.
REQ-023 Requests SHALL leave in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-024 On rst high, immediately and independent of clk: out_valid = 0, data_out = 0, dir = 0, ena = 0, issue_cnt = 0, skid buffer empty.
REQ-025 in_ready SHALL be 0 while rst is high.
REQ-026 Reset asserted mid-transfer SHALL discard all held requests; first accept after release SHALL be on the first edge with rst low.

Configuration
REQ-027 Macro SHIFT_ISSUE_SKID_EN defined: one-entry skid buffer is compiled in; in_ready SHALL be a registered signal, high whenever the skid entry is empty; a request arriving while the output is stalled SHALL be held in the skid entry and moved to the output when out_ready rises.
REQ-028 Macro SHIFT_ISSUE_SKID_EN undefined: no skid entry; in_ready SHALL equal (!out_valid || out_ready) combinationally.
REQ-029 Function, latency, reset values and ordering SHALL be identical in both builds apart from in_ready timing and the extra buffered entry.

Verification
REQ-030 Reset: assert rst asynchronously with out_valid high -> out_valid, ena, issue_cnt go 0 before next clk edge.
REQ-031 Single issue: in_data=32'h12345678, in_amt=17, in_dir=0 accepted -> next cycle data_out=32'h12345678, ena=5'b10001, dir=0, out_valid=1.
REQ-032 Back-to-back: 4 requests, out_ready held 1 -> 4 outputs on 4 consecutive cycles, in order, issue_cnt=4.
REQ-033 Stall: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable; with SKID_EN exactly one extra request buffered and in_ready drops; without SKID_EN in_ready=0 throughout.
REQ-034 Boundary amounts: in_amt=0 -> ena=0; in_amt=31, in_dir=1 -> ena=5'b11111, dir=1.
REQ-035 Saturation: force 65536 output handshakes -> issue_cnt holds 16'hFFFF.
